// File: rtl/rename_pkg.sv
// Shared rename types: map entries, checkpoint ids and the per-lane bypass request/result.
package rename_pkg;

  localparam int unsigned ARCH_REGS = 32;
  localparam int unsigned PHYS_REGS = 64;
  localparam int unsigned RENAME_W  = 2;
  localparam int unsigned NUM_CKPT  = 4;

  localparam int unsigned PHYS_W = $clog2(PHYS_REGS);
  localparam int unsigned ARCH_W = $clog2(ARCH_REGS);
  localparam int unsigned CKPT_W = $clog2(NUM_CKPT);
  localparam int unsigned LANE_W = (RENAME_W > 1) ? $clog2(RENAME_W) : 1;

  typedef logic [PHYS_W-1:0] phys_t;
  typedef logic [ARCH_W-1:0] arch_t;
  typedef logic [CKPT_W-1:0] ckpt_id_t;
  typedef logic [CKPT_W:0]   ckpt_cnt_t;
  typedef phys_t [ARCH_REGS-1:0] rat_map_t;

  typedef struct packed {
    logic  wr;
    arch_t rd;
    phys_t pd;
  } lane_wr_t;

  typedef struct packed {
    lane_wr_t [RENAME_W-1:0] wr;
    arch_t                   rs1;
    arch_t                   rs2;
    arch_t                   rd;
  } bypass_req_t;

  typedef struct packed {
    phys_t rs1;
    phys_t rs2;
    phys_t rd_old;
  } bypass_res_t;

  function automatic rat_map_t identity_map();
    rat_map_t m;
    for (int i = 0; i < int'(ARCH_REGS); i++) begin
      m[i] = phys_t'(i);
    end
    return m;
  endfunction

endpackage

// File: rtl/rat_ckpt_if.sv
// Rename, checkpoint, commit and flush signals between the frontend and the rename map.
interface rat_ckpt_if;
  import rename_pkg::*;

  arch_t [RENAME_W-1:0] rs1_arch;
  arch_t [RENAME_W-1:0] rs2_arch;
  arch_t [RENAME_W-1:0] rd_arch;
  logic  [RENAME_W-1:0] rename_valid;
  logic  [RENAME_W-1:0] rename_uses_rd;
  phys_t [RENAME_W-1:0] rename_pd_new;
  phys_t [RENAME_W-1:0] rs1_phys;
  phys_t [RENAME_W-1:0] rs2_phys;
  phys_t [RENAME_W-1:0] rd_old_phys;

  logic              ckpt_alloc_valid;
  logic [LANE_W-1:0] ckpt_lane;
  logic              ckpt_alloc_ready;
  ckpt_id_t          ckpt_alloc_id;
  logic              ckpt_free_valid;
  logic              ckpt_restore_valid;
  ckpt_id_t          ckpt_restore_id;
  ckpt_cnt_t         ckpt_count;

  logic  [RENAME_W-1:0] commit_valid;
  arch_t [RENAME_W-1:0] commit_rd_arch;
  phys_t [RENAME_W-1:0] commit_pd;
  logic                 flush_valid;

  modport master (
    output rs1_arch, rs2_arch, rd_arch, rename_valid, rename_uses_rd, rename_pd_new,
    output ckpt_alloc_valid, ckpt_lane, ckpt_free_valid, ckpt_restore_valid, ckpt_restore_id,
    output commit_valid, commit_rd_arch, commit_pd, flush_valid,
    input  rs1_phys, rs2_phys, rd_old_phys, ckpt_alloc_ready, ckpt_alloc_id, ckpt_count
  );

  modport slave (
    input  rs1_arch, rs2_arch, rd_arch, rename_valid, rename_uses_rd, rename_pd_new,
    input  ckpt_alloc_valid, ckpt_lane, ckpt_free_valid, ckpt_restore_valid, ckpt_restore_id,
    input  commit_valid, commit_rd_arch, commit_pd, flush_valid,
    output rs1_phys, rs2_phys, rd_old_phys, ckpt_alloc_ready, ckpt_alloc_id, ckpt_count
  );

endinterface

// File: rtl/rat_bypass.sv
// Source and rd_old lookup for one rename lane, forwarding from older lanes of the same group.
module rat_bypass
  import rename_pkg::*;
#(
  parameter int unsigned Lane = 0
) (
  input  rat_map_t    spec_rat,
  input  bypass_req_t req,
  output bypass_res_t res
);

  // Younger older-lane matches overwrite earlier ones, so the highest lane below us wins.
  function automatic phys_t resolve(rat_map_t m, lane_wr_t [RENAME_W-1:0] wr, arch_t src);
    phys_t p;
    p = m[src];
    for (int j = 0; j < int'(Lane); j++) begin
      if (wr[j].wr && (wr[j].rd == src)) p = wr[j].pd;
    end
    if (src == '0) p = '0;
    return p;
  endfunction

  always_comb begin
    res        = '0;
    res.rs1    = resolve(spec_rat, req.wr, req.rs1);
    res.rs2    = resolve(spec_rat, req.wr, req.rs2);
    res.rd_old = resolve(spec_rat, req.wr, req.rd);
  end

endmodule

// File: rtl/rat_ckpt.sv
// Multi-lane register alias table with a circular queue of branch snapshots and a
// retire-updated committed map used to recover precise state on flush.
module rat_ckpt
  import rename_pkg::*;
(
  input logic       clk,
  input logic       rst_n,
  rat_ckpt_if.slave bus
);

  rat_map_t  spec_rat_q, spec_rat_d;
  rat_map_t  arch_rat_q;
  rat_map_t  ckpt_q [NUM_CKPT];
  ckpt_id_t  head_q, head_d;
  ckpt_id_t  tail_q, tail_d;
  ckpt_cnt_t count_q, count_d;

  rat_map_t  rename_map;
  rat_map_t  ckpt_map;
  rat_map_t  commit_map;
  lane_wr_t [RENAME_W-1:0] lane_wr;
  logic      alloc_ok;
  logic      free_ok;
  logic      ckpt_wr;

  always_comb begin
    for (int i = 0; i < int'(RENAME_W); i++) begin
      lane_wr[i].wr = bus.rename_valid[i] & bus.rename_uses_rd[i];
      lane_wr[i].rd = bus.rd_arch[i];
      lane_wr[i].pd = bus.rename_pd_new[i];
    end
  end

  for (genvar g = 0; g < int'(RENAME_W); g++) begin : g_lane
    bypass_req_t req;
    bypass_res_t res;

    assign req.wr  = lane_wr;
    assign req.rs1 = bus.rs1_arch[g];
    assign req.rs2 = bus.rs2_arch[g];
    assign req.rd  = bus.rd_arch[g];

    rat_bypass #(
      .Lane(g)
    ) u_bypass (
      .spec_rat(spec_rat_q),
      .req     (req),
      .res     (res)
    );

    assign bus.rs1_phys[g]    = res.rs1;
    assign bus.rs2_phys[g]    = res.rs2;
    assign bus.rd_old_phys[g] = res.rd_old;
  end

  // Lanes are applied in order so the highest lane wins a shared rd.
  always_comb begin
    rename_map = spec_rat_q;
    ckpt_map   = spec_rat_q;
    for (int i = 0; i < int'(RENAME_W); i++) begin
      if (lane_wr[i].wr && (lane_wr[i].rd != '0)) begin
        rename_map[lane_wr[i].rd] = lane_wr[i].pd;
        if (i <= int'(bus.ckpt_lane)) ckpt_map[lane_wr[i].rd] = lane_wr[i].pd;
      end
    end
  end

  always_comb begin
    commit_map = arch_rat_q;
    for (int i = 0; i < int'(RENAME_W); i++) begin
      if (bus.commit_valid[i] && (bus.commit_rd_arch[i] != '0)) begin
        commit_map[bus.commit_rd_arch[i]] = bus.commit_pd[i];
      end
    end
  end

  assign bus.ckpt_alloc_ready = (count_q < ckpt_cnt_t'(NUM_CKPT));
  assign bus.ckpt_alloc_id    = tail_q;
  assign bus.ckpt_count       = count_q;

  assign alloc_ok = bus.ckpt_alloc_valid && bus.ckpt_alloc_ready;
  assign free_ok  = bus.ckpt_free_valid && (count_q != '0);
  assign ckpt_wr  = alloc_ok && !bus.flush_valid && !bus.ckpt_restore_valid;

  always_comb begin
    spec_rat_d = rename_map;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    if (bus.flush_valid) begin
      spec_rat_d = commit_map;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end else if (bus.ckpt_restore_valid) begin
      // Everything younger than the restored slot is discarded; the slot itself stays live.
      spec_rat_d = ckpt_q[bus.ckpt_restore_id];
      tail_d     = bus.ckpt_restore_id + ckpt_id_t'(1);
      head_d     = head_q + ckpt_id_t'(free_ok);
      count_d    = ckpt_cnt_t'(ckpt_id_t'(bus.ckpt_restore_id - head_q)) + ckpt_cnt_t'(1)
                   - ckpt_cnt_t'(free_ok);
    end else begin
      tail_d  = tail_q + ckpt_id_t'(alloc_ok);
      head_d  = head_q + ckpt_id_t'(free_ok);
      count_d = count_q + ckpt_cnt_t'(alloc_ok) - ckpt_cnt_t'(free_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      spec_rat_q <= identity_map();
      arch_rat_q <= identity_map();
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      spec_rat_q <= spec_rat_d;
      arch_rat_q <= commit_map;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  // Snapshot storage carries no reset; only live slots are ever restored.
  always_ff @(posedge clk) begin
    if (rst_n && ckpt_wr) ckpt_q[tail_q] <= ckpt_map;
  end

endmodule

// File: tb/tb_rat_ckpt.sv
// Directed and randomized check of rat_ckpt against an array-based rename map model.
module tb_rat_ckpt;
  import rename_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rat_ckpt_if bus ();

  rat_ckpt dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_fail = 0;

  int m_spec [32];
  int m_arch [32];
  int m_ckpt [4][32];
  int m_head, m_tail, m_count;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lane_writes(int j);
    return (bus.rename_valid[j] && bus.rename_uses_rd[j]) ? 1 : 0;
  endfunction

  // What a lane must see: nearest older lane writing src, else the speculative map.
  function automatic int exp_read(int lane, int src);
    if (src == 0) return 0;
    for (int j = lane - 1; j >= 0; j--) begin
      if (lane_writes(j) != 0 && int'(bus.rd_arch[j]) == src) return int'(bus.rename_pd_new[j]);
    end
    return m_spec[src];
  endfunction

  task automatic model_step();
    int na [32];
    int snap [32];
    int c0, f, id;
    if (!rst_n) begin
      for (int r = 0; r < 32; r++) begin
        m_spec[r] = r;
        m_arch[r] = r;
      end
      m_head = 0; m_tail = 0; m_count = 0;
    end else begin
      na = m_arch;
      for (int i = 0; i < 2; i++)
        if (bus.commit_valid[i] && bus.commit_rd_arch[i] != 0)
          na[bus.commit_rd_arch[i]] = int'(bus.commit_pd[i]);
      c0 = m_count;
      f = (bus.ckpt_free_valid && c0 > 0) ? 1 : 0;
      if (bus.flush_valid) begin
        m_spec = na;
        m_head = 0; m_tail = 0; m_count = 0;
      end else if (bus.ckpt_restore_valid) begin
        id = int'(bus.ckpt_restore_id);
        m_spec = m_ckpt[id];
        m_count = ((id - m_head + 4) % 4) + 1 - f;
        m_head = (m_head + f) % 4;
        m_tail = (id + 1) % 4;
      end else begin
        snap = m_spec;
        for (int i = 0; i < 2; i++) begin
          if (lane_writes(i) != 0 && bus.rd_arch[i] != 0) begin
            m_spec[bus.rd_arch[i]] = int'(bus.rename_pd_new[i]);
            if (i <= int'(bus.ckpt_lane)) snap[bus.rd_arch[i]] = int'(bus.rename_pd_new[i]);
          end
        end
        if (bus.ckpt_alloc_valid && c0 < 4) begin
          m_ckpt[m_tail] = snap;
          m_tail = (m_tail + 1) % 4;
          m_count++;
        end
        if (f != 0) begin
          m_head = (m_head + 1) % 4;
          m_count--;
        end
      end
      m_arch = na;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Cycle-by-cycle compare of every output against the model.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("lane%0d_rs1", i), 32'(bus.rs1_phys[i]), exp_read(i, bus.rs1_arch[i]));
        chk($sformatf("lane%0d_rs2", i), 32'(bus.rs2_phys[i]), exp_read(i, bus.rs2_arch[i]));
        chk($sformatf("lane%0d_rd_old", i), 32'(bus.rd_old_phys[i]),
            exp_read(i, bus.rd_arch[i]));
      end
      chk("ready", 32'(bus.ckpt_alloc_ready), (m_count < 4) ? 1 : 0);
      chk("alloc_id", 32'(bus.ckpt_alloc_id), m_tail);
      chk("count", 32'(bus.ckpt_count), m_count);
    end
  end

  task automatic idle();
    bus.rs1_arch = '0; bus.rs2_arch = '0; bus.rd_arch = '0;
    bus.rename_valid = '0; bus.rename_uses_rd = '0; bus.rename_pd_new = '0;
    bus.ckpt_alloc_valid = 1'b0; bus.ckpt_lane = '0; bus.ckpt_free_valid = 1'b0;
    bus.ckpt_restore_valid = 1'b0; bus.ckpt_restore_id = '0;
    bus.commit_valid = '0; bus.commit_rd_arch = '0; bus.commit_pd = '0;
    bus.flush_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
    idle();
  endtask

  task automatic look();
    @(negedge clk);
    #1;
  endtask

  task automatic rename(int lane, int rd, int pd);
    bus.rename_valid[lane] = 1'b1;
    bus.rename_uses_rd[lane] = 1'b1;
    bus.rd_arch[lane] = arch_t'(rd);
    bus.rename_pd_new[lane] = phys_t'(pd);
  endtask

  initial begin
    idle();
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // Reset map is identity
    bus.rs1_arch[0] = 5; bus.rs2_arch[0] = 7;
    look();
    chk("rst_rs1", 32'(bus.rs1_phys[0]), 5);
    chk("rst_rs2", 32'(bus.rs2_phys[0]), 7);
    chk("rst_ready", 32'(bus.ckpt_alloc_ready), 1);
    chk("rst_count", 32'(bus.ckpt_count), 0);
    step();

    // Intra-group bypass plus a snapshot taken after lane 0
    rename(0, 3, 40);
    rename(1, 3, 41);
    bus.rs1_arch[1] = 3;
    bus.ckpt_alloc_valid = 1'b1; bus.ckpt_lane = 0;
    look();
    chk("byp_rs1", 32'(bus.rs1_phys[1]), 40);
    chk("byp_rd_old", 32'(bus.rd_old_phys[1]), 40);
    chk("byp_l0_rd_old", 32'(bus.rd_old_phys[0]), 3);
    chk("first_id", 32'(bus.ckpt_alloc_id), 0);
    step();
    bus.rs1_arch[0] = 3;
    rename(0, 3, 50);
    look();
    chk("x3_after", 32'(bus.rs1_phys[0]), 41);
    chk("count_one", 32'(bus.ckpt_count), 1);
    step();
    bus.rs1_arch[0] = 3;
    look();
    chk("x3_50", 32'(bus.rs1_phys[0]), 50);
    bus.ckpt_restore_valid = 1'b1; bus.ckpt_restore_id = 0;
    step();
    bus.rs1_arch[0] = 3;
    look();
    chk("restore_x3", 32'(bus.rs1_phys[0]), 40);
    chk("restore_count", 32'(bus.ckpt_count), 1);

    // Fill the queue, refuse while full even with a same-cycle free, wrap the id
    step();
    for (int k = 0; k < 3; k++) begin
      bus.ckpt_alloc_valid = 1'b1;
      step();
    end
    look();
    chk("full_ready", 32'(bus.ckpt_alloc_ready), 0);
    chk("full_count", 32'(bus.ckpt_count), 4);
    bus.ckpt_alloc_valid = 1'b1;
    step();
    look();
    chk("refused_count", 32'(bus.ckpt_count), 4);
    bus.ckpt_alloc_valid = 1'b1; bus.ckpt_free_valid = 1'b1;
    step();
    look();
    chk("freed_ready", 32'(bus.ckpt_alloc_ready), 1);
    chk("freed_count", 32'(bus.ckpt_count), 3);
    chk("wrap_id", 32'(bus.ckpt_alloc_id), 0);

    // Flush restores the committed map
    step();
    bus.commit_valid[0] = 1'b1; bus.commit_rd_arch[0] = 3; bus.commit_pd[0] = 40;
    rename(0, 3, 55);
    step();
    bus.flush_valid = 1'b1;
    step();
    bus.rs1_arch[0] = 3; bus.rs2_arch[0] = 5; bus.rs1_arch[1] = 9;
    look();
    chk("flush_x3", 32'(bus.rs1_phys[0]), 40);
    chk("flush_x5", 32'(bus.rs2_phys[0]), 5);
    chk("flush_x9", 32'(bus.rs1_phys[1]), 9);
    chk("flush_count", 32'(bus.ckpt_count), 0);

    // Writes to x0 are dropped; flush beats a same-cycle restore
    step();
    rename(0, 0, 60);
    bus.commit_valid[0] = 1'b1; bus.commit_rd_arch[0] = 0; bus.commit_pd[0] = 61;
    bus.rs1_arch[1] = 0;
    look();
    chk("x0_byp", 32'(bus.rs1_phys[1]), 0);
    step();
    bus.flush_valid = 1'b1;
    step();
    look();
    chk("x0_read", 32'(bus.rs1_phys[0]), 0);
    rename(0, 4, 44);
    bus.ckpt_alloc_valid = 1'b1; bus.ckpt_lane = 0;
    step();
    bus.ckpt_restore_valid = 1'b1; bus.ckpt_restore_id = 0; bus.flush_valid = 1'b1;
    step();
    bus.rs1_arch[0] = 4;
    look();
    chk("rf_x4", 32'(bus.rs1_phys[0]), 4);
    chk("rf_count", 32'(bus.ckpt_count), 0);

    // Randomized traffic
    step();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < 2; i++) begin
        bus.rs1_arch[i] = arch_t'($urandom_range(0, 7));
        bus.rs2_arch[i] = arch_t'($urandom_range(0, 7));
        bus.rd_arch[i] = arch_t'($urandom_range(0, 7));
        bus.rename_valid[i] = ($urandom_range(0, 3) != 0);
        bus.rename_uses_rd[i] = ($urandom_range(0, 3) != 0);
        bus.rename_pd_new[i] = phys_t'($urandom_range(0, 63));
        bus.commit_valid[i] = ($urandom_range(0, 1) != 0);
        bus.commit_rd_arch[i] = arch_t'($urandom_range(0, 7));
        bus.commit_pd[i] = phys_t'($urandom_range(0, 63));
      end
      bus.ckpt_alloc_valid = ($urandom_range(0, 9) < 4);
      bus.ckpt_lane = LANE_W'($urandom_range(0, 1));
      bus.ckpt_free_valid = ($urandom_range(0, 9) < 3);
      if (m_count > 0 && $urandom_range(0, 19) == 0) begin
        bus.ckpt_restore_valid = 1'b1;
        bus.ckpt_restore_id = ckpt_id_t'((m_head + int'($urandom_range(0, m_count - 1))) % 4);
      end
      bus.flush_valid = ($urandom_range(0, 49) == 0);
      step();
    end

    look();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/rat_ckpt.md
# rat_ckpt

Multi-lane register alias table with branch checkpoints and a committed-state shadow; the next-generation rename map for the out-of-order core. Each cycle it renames up to RENAME_W instructions with intra-group dependency bypass and returns previous destination mappings for freelist reclaim. Snapshots of the speculative map are taken at branches for single-cycle mispredict recovery. A committed RAT, updated at retire, restores precise state on a full flush instead of the identity map.

## Interface
- ARCH_REGS, 32, architectural registers; register 0 is hardwired to phys 0.
- PHYS_REGS, 64, physical registers.
- RENAME_W, 2, rename and commit lanes per cycle.
- NUM_CKPT, 4, checkpoint slots (power of two).
- PHYS_W / ARCH_W / CKPT_W, $clog2 of the above, derived.

- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- rs1_arch, rs2_arch, rd_arch  in  RENAME_W×ARCH_W  per-lane source and destination arch regs
- rename_valid, rename_uses_rd  in  RENAME_W  lane valid; lane writes rd
- rename_pd_new  in  RENAME_W×PHYS_W  newly allocated phys reg per lane
- rs1_phys, rs2_phys  out  RENAME_W×PHYS_W  bypassed source mappings
- rd_old_phys  out  RENAME_W×PHYS_W  prior mapping of rd_arch (bypassed), for freeing at commit
- ckpt_alloc_valid  in  1  take a snapshot this cycle
- ckpt_lane  in  $clog2(RENAME_W)  lane holding the branch
- ckpt_alloc_ready  out  1  a slot is free
- ckpt_alloc_id  out  CKPT_W  id granted to this cycle's alloc
- ckpt_free_valid  in  1  oldest checkpoint resolved correctly; release it
- ckpt_restore_valid, ckpt_restore_id  in  1, CKPT_W  mispredict: restore snapshot
- commit_valid  in  RENAME_W  retire lanes (lane 0 oldest)
- commit_rd_arch, commit_pd  in  RENAME_W×ARCH_W, RENAME_W×PHYS_W  retiring mapping
- flush_valid  in  1  restore the committed map; drop all checkpoints
- ckpt_count  out  CKPT_W+1  occupied slots

## Operation
- Storage: spec_rat, arch_rat (ARCH_REGS×PHYS_W); ckpt[NUM_CKPT] full-map snapshots; head, tail (CKPT_W) and count form a circular queue.
- Reads are combinational. Lane i's rs1/rs2/rd_old take the rd_pd_new of the highest lane j<i with rename_valid[j] && rename_uses_rd[j] && rd_arch[j]==src and src!=0; otherwise spec_rat[src]. Arch reg 0 always reads 0.
- Rename write: every valid lane with uses_rd and rd_arch!=0 writes spec_rat; for the same rd the higher lane wins. Writes to arch 0 are dropped.
- Alloc (ckpt_alloc_valid && ckpt_alloc_ready): ckpt[tail] <= spec_rat with lanes 0..ckpt_lane of this cycle's renames applied; tail++, count++. ckpt_alloc_id = tail at all times. An alloc while not ready is ignored with no state change; the frontend must stall.
- Free: head++, count--. Checkpoints are freed in order (oldest branch first). A free with count==0 is illegal and ignored.
- Restore: spec_rat <= ckpt[id]; tail <= id+1; count <= ((id-head) mod NUM_CKPT)+1 − free. The restored slot remains live until it is freed. A same-cycle rename and alloc are discarded. A same-cycle free is applied first.
- Commit: arch_rat[commit_rd_arch[i]] <= commit_pd[i] for valid lanes with rd!=0. For the same rd the higher lane wins. Commit proceeds independently of all other events.
- Flush: spec_rat <= arch_rat including this cycle's commits; head = tail = count = 0. Rename, alloc, free and restore are ignored.
- Priority: reset > flush > restore > (rename, alloc, free).

## Timing
- Read and bypass have zero latency. All state updates take effect at the next posedge. A lookup in the cycle after a rename or restore sees the new map.
- Reset: spec_rat and arch_rat are identity (rat[i]=i); head=tail=count=0; ckpt_alloc_ready=1; ckpt_alloc_id=0; ckpt_count=0. Snapshot contents are don't-care. rs*_phys reflect the identity map in the cycle after reset.
- ckpt_alloc_ready = (count<NUM_CKPT) and is registered-state only, with no combinational path from the same-cycle free. tail and head wrap modulo NUM_CKPT.
- When full, a same-cycle free and alloc: the alloc is still refused.

## Structure
- Shared package rename_pkg: phys_t, arch_t, ckpt_id_t, rat_map_t (ARCH_REGS×phys_t).
- One sub-module, rat_bypass: the combinational intra-group source and rd_old bypass for one lane, instantiated RENAME_W times (3 ports each).

## Test plan
- Reset then read lanes x5/x7 -> rs1_phys=5, rs2_phys=7, ckpt_alloc_ready=1, ckpt_count=0.
- Lane0 renames x3->40 and lane1 reads rs1=x3 and writes x3->41 in the same cycle -> lane1 rs1_phys=40, rd_old_phys=40; next cycle x3 reads 41.
- Alloc checkpoint with ckpt_lane=0 in the same cycle as the above group, then rename x3->50; restore that id -> x3 reads 40 and count=1.
- Allocate 4 checkpoints -> ready=0 and a 5th alloc is ignored; free one -> ready=1 with head=1, and the next alloc_id wraps to 0.
- Commit x3->40 and rename x3->55, then flush -> x3 reads 40 and all other regs read identity; count=0.
- Rename and commit writing x0 -> x0 still reads 0; restore and flush asserted together -> flush result wins.
